// File: rtl/rptr_sync_handler.sv
// -----------------------------------------------------------------------------
// rptr_sync_handler
//
// Read-side pointer controller for an asynchronous FIFO. It brings the Gray
// write pointer into the read clock domain through a two-flop synchroniser and
// maintains the binary and Gray read pointers. It also produces registered
// empty, almost-empty and fill-level status.
//
// Optional feature macro: RPTR_UNDERFLOW_EN
//   defined   : runderflow is a sticky register. It is set by a read while
//               empty and cleared by rclr_err or by reset. Set wins over clear.
//   undefined : no register; runderflow is tied to 0 and rclr_err is ignored.
//
// Parameters
//   ADDR_SIZE     : memory address width, FIFO depth = 2**ADDR_SIZE
//   AEMPTY_THRESH : raempty asserts when the fill level <= this value
//
// Ports
//   rclk       in   read clock (only clock in the block)
//   rrst_n     in   synchronous active-low reset
//   rinc       in   read request; consumes one entry when rinc & ~rempty
//   rclr_err   in   clears the sticky underflow flag
//   wptr       in   Gray write pointer, asynchronous to rclk
//   raddr      out  memory read address (low bits of the binary read pointer)
//   rptr       out  registered Gray read pointer, exported to the write domain
//   rempty     out  registered empty flag
//   raempty    out  registered almost-empty flag
//   rlevel     out  registered fill level, 0..2**ADDR_SIZE
//   runderflow out  sticky underflow error
// -----------------------------------------------------------------------------
module rptr_sync_handler #(
   parameter int ADDR_SIZE     = 4,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 rinc,
   input  logic                 rclr_err,
   input  logic [ADDR_SIZE:0]   wptr,
   output logic [ADDR_SIZE-1:0] raddr,
   output logic [ADDR_SIZE:0]   rptr,
   output logic                 rempty,
   output logic                 raempty,
   output logic [ADDR_SIZE:0]   rlevel,
   output logic                 runderflow
);

   localparam logic [ADDR_SIZE:0] AEMPTY_LVL = (ADDR_SIZE+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_SIZE:0] PTR_ZERO   = {(ADDR_SIZE+1){1'b0}};

   // Binary to reflected Gray code.
   function automatic logic [ADDR_SIZE:0] bin2gray(input logic [ADDR_SIZE:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Gray to binary: XOR prefix running down from the MSB.
   function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
      logic [ADDR_SIZE:0] b;
      b[ADDR_SIZE] = g[ADDR_SIZE];
      for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_SIZE:0] rq1_wptr_r;
   logic [ADDR_SIZE:0] rq2_wptr_r;
   logic [ADDR_SIZE:0] rbin_r;

   logic               rd_en_s;
   logic [ADDR_SIZE:0] rbin_next_s;
   logic [ADDR_SIZE:0] rgray_next_s;
   logic [ADDR_SIZE:0] wbin_s;
   logic [ADDR_SIZE:0] level_next_s;

   // Next-pointer and next-level arithmetic; empty blocks the increment.
   always_comb begin
      rd_en_s      = rinc & ~rempty;
      rbin_next_s  = rbin_r + {{ADDR_SIZE{1'b0}}, rd_en_s};
      rgray_next_s = bin2gray(rbin_next_s);
      wbin_s       = gray2bin(rq2_wptr_r);
      // Modulo 2**(ADDR_SIZE+1) difference; the extra MSB separates full from empty.
      level_next_s = wbin_s - rbin_next_s;
   end

   // Two-flop synchroniser for the incoming Gray write pointer.
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rq1_wptr_r <= PTR_ZERO;
         rq2_wptr_r <= PTR_ZERO;
      end else begin
         rq1_wptr_r <= wptr;
         rq2_wptr_r <= rq1_wptr_r;
      end
   end

   // Read pointers and status flags. rptr is registered so that it changes
   // by exactly one bit per increment as seen by the write domain.
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rbin_r  <= PTR_ZERO;
         rptr    <= PTR_ZERO;
         rempty  <= 1'b1;
         raempty <= 1'b1;
         rlevel  <= PTR_ZERO;
      end else begin
         rbin_r  <= rbin_next_s;
         rptr    <= rgray_next_s;
         rempty  <= (rgray_next_s == rq2_wptr_r);
         raempty <= (level_next_s <= AEMPTY_LVL);
         rlevel  <= level_next_s;
      end
   end

   assign raddr = rbin_r[ADDR_SIZE-1:0];

`ifdef RPTR_UNDERFLOW_EN
   // Sticky underflow flag; a read while empty takes priority over a clear.
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         runderflow <= 1'b0;
      end else if (rinc & rempty) begin
         runderflow <= 1'b1;
      end else if (rclr_err) begin
         runderflow <= 1'b0;
      end else begin
         runderflow <= runderflow;
      end
   end
`else
   logic unused_clr_s;
   assign unused_clr_s = rclr_err;
   assign runderflow   = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_sync_handler.sv
// Self-checking bench for rptr_sync_handler (ADDR_SIZE=4, AEMPTY_THRESH=2).
// The reference model tracks integer write/read counts and a two-stage delay
// of the write count; expected pointers are derived from those counts.
module tb_rptr_sync_handler;

   logic       rclk = 1'b0;
   logic       rrst_n = 1'b0;
   logic       rinc = 1'b0;
   logic       rclr_err = 1'b0;
   logic [4:0] wptr = 5'b00000;
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic       rempty;
   logic       raempty;
   logic [4:0] rlevel;
   logic       runderflow;

   int errors = 0;
   int checks = 0;

   // reference model state (counts are totals, reduced mod 32 where needed)
   int  wcnt = 0;
   int  m_r = 0;
   int  m_s1 = 0;
   int  m_s2 = 0;
   int  m_level = 0;
   bit  m_empty = 1'b1;
   bit  m_aempty = 1'b1;
   bit  m_uf = 1'b0;
   int  m_reads = 0;

   rptr_sync_handler #(.ADDR_SIZE(4), .AEMPTY_THRESH(2)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rclr_err(rclr_err),
      .wptr(wptr), .raddr(raddr), .rptr(rptr), .rempty(rempty),
      .raempty(raempty), .rlevel(rlevel), .runderflow(runderflow)
   );

   always #5 rclk = ~rclk;

   function automatic logic [4:0] gray(input int n);
      int b;
      b = n % 32;
      return 5'(b ^ (b >> 1));
   endfunction

   task automatic set_w(input int n);
      wcnt = n;
      wptr = gray(n);
   endtask

   // Advance one clock and update the model with the inputs seen at that edge.
   task automatic step();
      bit acc;
      bit old_empty;
      @(posedge rclk);
      if (!rrst_n) begin
         m_r = 0; m_s1 = 0; m_s2 = 0; m_level = 0;
         m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
      end else begin
         old_empty = m_empty;
         acc = rinc && !old_empty;
         if (acc) begin
            m_r = m_r + 1;
            m_reads = m_reads + 1;
         end
         m_level  = ((m_s2 % 32) + 32 - (m_r % 32)) % 32;
         m_empty  = (m_level == 0);
         m_aempty = (m_level <= 2);
`ifdef RPTR_UNDERFLOW_EN
         if (rinc && old_empty) m_uf = 1'b1;
         else if (rclr_err) m_uf = 1'b0;
`endif
         m_s2 = m_s1;
         m_s1 = wcnt;
      end
      #1;
   endtask

   task automatic do_reset();
      rrst_n = 1'b0; rinc = 1'b0; rclr_err = 1'b0;
      set_w(0);
      step();
      rrst_n = 1'b1;
      m_reads = 0;
   endtask

   task automatic test_reset();
      rrst_n = 1'b0; rinc = 1'b1; rclr_err = 1'b0;
      wptr = 5'b00110;
      step();
      step();
      checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b want 1", rempty); end
      checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL reset_raempty: got %b want 1", raempty); end
      checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL reset_rlevel: got %0d want 0", rlevel); end
      checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL reset_rptr: got %b want 0", rptr); end
      checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
      checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL reset_runderflow: got %b want 0", runderflow); end
      rinc = 1'b0;
      set_w(0);
      rrst_n = 1'b1;
      step();
      step();
   endtask

   task automatic test_sync_latency();
      logic [4:0] exp_lvl [3] = '{5'd2, 5'd1, 5'd0};
      set_w(3);                   // stable before edge N
      step();                     // edge N
      step();                     // edge N+1
      checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL lat_early_empty: got %b want 1 at N+1", rempty); end
      step();                     // edge N+2
      checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL lat_empty: got %b want 0 at N+2", rempty); end
      checks++; if (rlevel !== 5'd3) begin errors++; $display("FAIL lat_level: got %0d want 3", rlevel); end
      checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL lat_aempty: got %b want 0", raempty); end
      rinc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (rlevel !== exp_lvl[i]) begin errors++; $display("FAIL lat_read_level[%0d]: got %0d want %0d", i, rlevel, exp_lvl[i]); end
         checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL lat_read_aempty[%0d]: got %b want 1", i, raempty); end
         checks++; if (rempty !== (i == 2)) begin errors++; $display("FAIL lat_read_empty[%0d]: got %b want %b", i, rempty, (i == 2)); end
      end
      rinc = 1'b0;
      step();
   endtask

   task automatic test_drain_wrap();
      do_reset();
      for (int lap = 1; lap <= 2; lap++) begin
         set_w(16 * lap);
         step(); step(); step();
         checks++; if (rlevel !== 5'd16) begin errors++; $display("FAIL wrap_full_level lap%0d: got %0d want 16", lap, rlevel); end
         rinc = 1'b1;
         for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (raddr !== 4'((i + 1) % 16)) begin errors++; $display("FAIL wrap_raddr lap%0d[%0d]: got %0d want %0d", lap, i, raddr, (i + 1) % 16); end
         end
         rinc = 1'b0;
         checks++; if (rptr !== gray(16 * lap)) begin errors++; $display("FAIL wrap_rptr lap%0d: got %b want %b", lap, rptr, gray(16 * lap)); end
         checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL wrap_empty lap%0d: got %b want 1", lap, rempty); end
         checks++; if (dut.rbin_r !== 5'((16 * lap) % 32)) begin errors++; $display("FAIL wrap_rbin lap%0d: got %0d want %0d", lap, dut.rbin_r, (16 * lap) % 32); end
      end
      // reset with data still in flight returns pointers to 0
      set_w(37);
      step(); step(); step();
      rrst_n = 1'b0; step(); rrst_n = 1'b1; set_w(0);
      checks++; if (rptr !== 5'd0 || rempty !== 1'b1 || rlevel !== 5'd0) begin errors++; $display("FAIL mid_reset: got rptr=%b empty=%b level=%0d want 0/1/0", rptr, rempty, rlevel); end
      step(); step();
   endtask

   task automatic test_underflow();
      logic [4:0] p0;
      logic       exp_set;
`ifdef RPTR_UNDERFLOW_EN
      exp_set = 1'b1;
`else
      exp_set = 1'b0;
`endif
      p0 = rptr;
      rinc = 1'b1; step(); rinc = 1'b0;
      checks++; if (rptr !== p0) begin errors++; $display("FAIL uf_rptr_hold: got %b want %b", rptr, p0); end
      checks++; if (runderflow !== exp_set) begin errors++; $display("FAIL uf_set: got %b want %b", runderflow, exp_set); end
      step();
      checks++; if (runderflow !== exp_set) begin errors++; $display("FAIL uf_sticky: got %b want %b", runderflow, exp_set); end
      rclr_err = 1'b1; step(); rclr_err = 1'b0;
      checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", runderflow); end
      rinc = 1'b1; rclr_err = 1'b1; step(); rinc = 1'b0; rclr_err = 1'b0;
      checks++; if (runderflow !== exp_set) begin errors++; $display("FAIL uf_set_wins: got %b want %b", runderflow, exp_set); end
      checks++; if (rptr !== p0 || rempty !== 1'b1) begin errors++; $display("FAIL uf_ptr_after: got rptr=%b empty=%b want %b/1", rptr, rempty, p0); end
      rclr_err = 1'b1; step(); rclr_err = 1'b0;
      checks++; if (runderflow !== m_uf) begin errors++; $display("FAIL uf_model: got %b want %b", runderflow, m_uf); end
   endtask

   task automatic test_continuous();
      int start_reads;
      int start_w;
      int n;
      start_reads = m_reads;
      start_w     = wcnt;
      for (int c = 0; c < 300; c++) begin
         // writer advances at most one Gray step per cycle and never overfills
         if ((wcnt - m_r) < 16 && (c < 40 || $urandom_range(0, 3) != 0)) set_w(wcnt + 1);
         rinc = (c < 40) ? 1'b1 : 1'($urandom_range(0, 4) != 0);
         step();
         checks++;
         if (rptr !== gray(m_r) || raddr !== 4'(m_r % 16) || rempty !== m_empty ||
             raempty !== m_aempty || rlevel !== 5'(m_level) || runderflow !== m_uf) begin
            errors++;
            $display("FAIL cont[%0d]: got rptr=%b raddr=%0d empty=%b aempty=%b level=%0d uf=%b want %b/%0d/%b/%b/%0d/%b",
                     c, rptr, raddr, rempty, raempty, rlevel, runderflow,
                     gray(m_r), m_r % 16, m_empty, m_aempty, m_level, m_uf);
         end
         checks++; if (rlevel > 5'd16) begin errors++; $display("FAIL cont_level_max[%0d]: got %0d want <=16", c, rlevel); end
      end
      // stop writing and drain within a bounded number of cycles
      rinc = 1'b1;
      n = 0;
      while (!(m_empty && m_s2 == wcnt) && n < 64) begin
         step();
         n++;
      end
      step(); step(); step();
      rinc = 1'b0;
      rclr_err = 1'b1; step(); rclr_err = 1'b0;
      checks++; if (n >= 64) begin errors++; $display("FAIL cont_drain_timeout: got %0d cycles want <64", n); end
      checks++; if ((m_reads - start_reads) != (wcnt - start_w)) begin errors++; $display("FAIL cont_counts: got %0d reads want %0d", m_reads - start_reads, wcnt - start_w); end
      checks++; if (rptr !== gray(wcnt) || rempty !== 1'b1) begin errors++; $display("FAIL cont_final: got rptr=%b empty=%b want %b/1", rptr, rempty, gray(wcnt)); end
   endtask

   initial begin
      test_reset();
      test_sync_latency();
      test_drain_wrap();
      test_underflow();
      test_continuous();
      test_underflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
